branch_target_buffer: RTL and testbench

//  Parametrised, direct-mapped branch target buffer (BTB) for the IF stage of
//  the RV32I pipeline. Predicts taken/not-taken with 2-bit saturating counters
//  and supplies the next fetch PC.
//  On a BTB miss it falls back to static backward-taken/forward-not-taken
//  (BTFN) prediction, using the B-type immediate decoded from the fetched word.
//  The EX stage trains the table with each resolved branch.

---
 rtl/rv32_pkg.sv | 17 +
 rtl/sat_ctr2.sv | 20 ++
 rtl/branch_target_buffer.sv | 114 +++++++++++
 tb/tb_branch_target_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: branch opcode, 2-bit counter encodings and
// the B-type immediate extractor shared by the BTB and the decoder.
package rv32_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Sign-extended 13-bit B-type immediate; bit 0 is always zero.
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_ctr2
    import rv32_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr_nxt
);

    always_comb begin
        o_ctr_nxt = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST)
                o_ctr_nxt = i_ctr + 2'd1;
        end else if (i_ctr != CTR_SNT) begin
            o_ctr_nxt = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters and BTFN fallback on a miss.
// Lookup is combinational off the registered table; EX trains it at the edge.
module branch_target_buffer
    import rv32_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_instr,
    output logic             pred_taken,
    output logic             pred_hit,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    output logic [CNT_W-1:0] perf_lookups,
    output logic [CNT_W-1:0] perf_hits
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Flat registers rather than a RAM so the whole table clears in one edge.
    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [CNT_W-1:0]  r_perf_lookups;
    logic [CNT_W-1:0]  r_perf_hits;

    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_if_hit;
    logic [31:0]       w_pc4;
    logic [31:0]       w_imm;
    logic              w_btfn_taken;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_ex_hit;
    logic [1:0]        w_ctr_nxt;
    logic              w_unused;

    assign w_if_idx     = if_pc[IDX_W+1:2];
    assign w_if_tag     = if_pc[31:IDX_W+2];
    assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_pc4        = if_pc + 32'd4;
    assign w_imm        = b_imm(if_instr);
    assign w_btfn_taken = (if_instr[6:0] == OPC_BRANCH) && w_imm[31];

    assign w_ex_idx     = ex_pc[IDX_W+1:2];
    assign w_ex_tag     = ex_pc[31:IDX_W+2];
    assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_unused     = ^{if_pc[1:0], ex_pc[1:0]};

    always_comb begin
        pred_hit    = w_if_hit;
        pred_taken  = 1'b0;
        pred_target = w_pc4;
        if (w_if_hit) begin
            pred_taken = r_ctr[w_if_idx][1];
            if (r_ctr[w_if_idx][1])
                pred_target = r_target[w_if_idx];
        end else if (w_btfn_taken) begin
            pred_taken  = 1'b1;
            pred_target = if_pc + w_imm;
        end
    end

    sat_ctr2 u_sat_ctr2 (
        .i_ctr     (r_ctr[w_ex_idx]),
        .i_taken   (ex_taken),
        .o_ctr_nxt (w_ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WNT;
            end
            r_perf_lookups <= '0;
            r_perf_hits    <= '0;
        end else begin
            if (ex_valid) begin
                if (w_ex_hit) begin
                    r_ctr[w_ex_idx] <= w_ctr_nxt;
                    if (ex_taken)
                        r_target[w_ex_idx] <= ex_target;
                end else begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= ex_target;
                    r_ctr[w_ex_idx]    <= ex_taken ? CTR_WT : CTR_WNT;
                end
            end
            if (if_valid) begin
                r_perf_lookups <= r_perf_lookups + CNT_W'(1);
                if (w_if_hit)
                    r_perf_hits <= r_perf_hits + CNT_W'(1);
            end
        end
    end

    assign perf_lookups = r_perf_lookups;
    assign perf_hits    = r_perf_hits;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRIES=16): lookups, training,
// aliasing, read-before-write and reset/perf behaviour.
module tb_branch_target_buffer;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
    localparam logic [31:0] BEQ_P16 = 32'h0000_0863;
    localparam logic [31:0] JAL_NEG = 32'hFE00_0CEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] perf_lookups;
    logic [31:0] perf_hits;

    int total = 0;
    int bad   = 0;

    branch_target_buffer #(.ENTRIES(16), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .pred_taken   (pred_taken),
        .pred_hit     (pred_hit),
        .pred_target  (pred_target),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target),
        .perf_lookups (perf_lookups),
        .perf_hits    (perf_hits)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic [31:0] instr);
        if_pc    = pc;
        if_instr = instr;
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_taken  = tk;
        ex_target = tgt;
        tick();
        ex_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
        ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        tick(); tick();
        reset = 1'b0;

        // T1 reset state and non-branch miss
        look(32'h100, ADDI);
        chk("t1_hit", pred_hit, 0);
        chk("t1_taken", pred_taken, 0);
        chk("t1_target", pred_target, 32'h104);
        chk("t1_lookups", perf_lookups, 0);
        chk("t1_hits", perf_hits, 0);

        // T2 BTFN fallback
        look(32'h200, BEQ_M8);
        chk("t2_bwd_taken", pred_taken, 1);
        chk("t2_bwd_target", pred_target, 32'h1F8);
        chk("t2_bwd_hit", pred_hit, 0);
        look(32'h200, BEQ_P16);
        chk("t2_fwd_taken", pred_taken, 0);
        chk("t2_fwd_target", pred_target, 32'h204);
        look(32'h200, JAL_NEG);
        chk("t2_nonbr_taken", pred_taken, 0);
        chk("t2_nonbr_target", pred_target, 32'h204);
        look(32'hFFFF_FFFC, ADDI);
        chk("t2_wrap_pc4", pred_target, 32'h0);
        look(32'h4, BEQ_M8);
        chk("t2_wrap_bwd", pred_target, 32'hFFFF_FFFC);

        // T3 training at 0x300
        train(32'h300, 1, 32'h340);
        look(32'h300, ADDI);
        chk("t3_alloc_hit", pred_hit, 1);
        chk("t3_alloc_taken", pred_taken, 1);
        chk("t3_alloc_target", pred_target, 32'h340);
        train(32'h300, 0, 32'h0);
        look(32'h300, ADDI);
        chk("t3_wnt_taken", pred_taken, 0);
        train(32'h300, 0, 32'h0);
        look(32'h300, ADDI);
        chk("t3_snt_hit", pred_hit, 1);
        chk("t3_snt_taken", pred_taken, 0);
        chk("t3_snt_target", pred_target, 32'h304);
        repeat (3) train(32'h300, 0, 32'h0);
        look(32'h300, ADDI);
        chk("t3_sat_taken", pred_taken, 0);
        train(32'h300, 1, 32'h380);
        look(32'h300, ADDI);
        chk("t3_sat_lo_taken", pred_taken, 0);
        chk("t3_sat_lo_target", pred_target, 32'h304);
        train(32'h300, 1, 32'h380);
        look(32'h300, ADDI);
        chk("t3_retrain_taken", pred_taken, 1);
        chk("t3_retarget", pred_target, 32'h380);

        // T4 aliasing on index 0
        train(32'h400, 1, 32'h480);
        train(32'h440, 0, 32'h4C0);
        look(32'h400, ADDI);
        chk("t4_evicted_hit", pred_hit, 0);
        chk("t4_evicted_target", pred_target, 32'h404);
        look(32'h440, ADDI);
        chk("t4_occ_hit", pred_hit, 1);
        chk("t4_occ_taken", pred_taken, 0);
        chk("t4_occ_target", pred_target, 32'h444);
        train(32'h440, 1, 32'h4C0);
        look(32'h440, ADDI);
        chk("t4_wnt_to_wt", pred_taken, 1);
        chk("t4_wt_target", pred_target, 32'h4C0);

        // T5 read-before-write on a strongly-taken entry
        repeat (3) train(32'h500, 1, 32'h540);
        ex_valid = 1'b1; ex_pc = 32'h500; ex_taken = 1'b0; ex_target = 32'h0;
        look(32'h500, ADDI);
        chk("t5_same_hit", pred_hit, 1);
        chk("t5_same_taken", pred_taken, 1);
        chk("t5_same_target", pred_target, 32'h540);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("t5_next_taken", pred_taken, 1);
        chk("t5_next_target", pred_target, 32'h540);
        train(32'h500, 0, 32'h0);
        look(32'h500, ADDI);
        chk("t5_wnt_taken", pred_taken, 0);

        // T6 perf counters and mid-run reset
        train(32'h604, 1, 32'h700);
        if_valid = 1'b1; if_pc = 32'h500; if_instr = ADDI;
        repeat (10) tick();
        if_pc = 32'h100;
        repeat (2) tick();
        if_valid = 1'b0;
        chk("t6_pre_lookups", perf_lookups, 12);
        chk("t6_pre_hits", perf_hits, 10);
        reset = 1'b1; if_valid = 1'b1; if_pc = 32'h500;
        ex_valid = 1'b1; ex_pc = 32'h608; ex_taken = 1'b1; ex_target = 32'h800;
        tick();
        reset = 1'b0; if_valid = 1'b0; ex_valid = 1'b0;
        chk("t6_rst_lookups", perf_lookups, 0);
        chk("t6_rst_hits", perf_hits, 0);
        look(32'h500, ADDI);
        chk("t6_rst_miss0", pred_hit, 0);
        look(32'h604, ADDI);
        chk("t6_rst_miss1", pred_hit, 0);
        chk("t6_rst_target1", pred_target, 32'h608);
        look(32'h608, ADDI);
        chk("t6_rst_noalloc", pred_hit, 0);
        train(32'h604, 1, 32'h700);
        if_valid = 1'b1; if_pc = 32'h604; if_instr = ADDI;
        repeat (3) tick();
        if_pc = 32'h100;
        repeat (2) tick();
        if_valid = 1'b0;
        chk("t6_post_lookups", perf_lookups, 5);
        chk("t6_post_hits", perf_hits, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
